uart_recv: RTL

- Synthesizable UART receiver: 8 data bits, no parity, 1 stop bit (8N1), LSB first. It is the counterpart of the team's serial transmit path.
- Takes the asynchronous serial line, synchronizes it, and frames bytes using a mid-bit sampling counter.
- Delivers each byte through a one-entry holding register with a valid/ack handshake.
- Used in the SoC UART peripheral and as the bench-side monitor for DUT serial output.

---
 rtl/uart_recv.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/uart_recv.sv
// Purpose : 8N1 UART receiver (LSB first) with 2-flop synchronizer, mid-bit sampling and a one-entry holding register.
// Latency : rx_valid is seen high after edge 3 + HALF_BIT + 9*CLKS_PER_BIT, counting the first edge where s1 captures the start bit as edge 1.
// Backpr. : no stall; a byte that arrives while rx_valid is high overwrites rx_data and sets the sticky rx_overrun flag.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   uart_rx        serial line, idle high, asynchronous to clk
//   rx_ack         consumer acknowledge; clears rx_valid and rx_overrun
//   rx_data        last correctly framed byte
//   rx_valid       rx_data holds an unread byte
//   rx_overrun     sticky: a byte arrived while rx_valid was high
//   rx_frame_error one-cycle pulse when the stop bit is sampled low
//   rx_busy        high whenever the receiver is not idle
module uart_recv #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_overrun,
    output logic       rx_frame_error,
    output logic       rx_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    // cnt never exceeds CLKS_PER_BIT-1, which always fits in clog2(CLKS_PER_BIT) bits.
    localparam int CNT_W        = (CLKS_PER_BIT < 4) ? 2 : $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

    // Below four clocks per bit the half-bit validation window collapses.
    if (CLKS_PER_BIT < 4) begin : g_bad_baud
        $error("uart_recv: CLKS_PER_BIT must be at least 4");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;
    logic             s1_q, s2_q;

    // Reset to the idle line level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= uart_rx;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        ferr_d  = 1'b0;

        if (rx_ack && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!s2_q) state_d = START;
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!s2_q) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {s2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (s2_q) begin
                        // An ack in this same cycle lets the new byte replace the
                        // acknowledged one without flagging an overrun.
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        if (valid_q && !rx_ack) ovr_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold off until the line goes idle so a long low level is one event.
                cnt_d = '0;
                if (s2_q) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign rx_data        = data_q;
    assign rx_valid       = valid_q;
    assign rx_overrun     = ovr_q;
    assign rx_frame_error = ferr_q;
    assign rx_busy        = (state_q != IDLE);

endmodule
